// File: rtl/car_pkg.sv
// car_pkg: shared mode/movement encodings, executor FSM states and command decoding
package car_pkg;
    localparam logic [3:0] STOP          = 4'b0000;
    localparam logic [3:0] MOVE_FORWARD  = 4'b0001;
    localparam logic [3:0] MOVE_BACKWARD = 4'b0010;
    localparam logic [3:0] TURN_LEFT     = 4'b0100;
    localparam logic [3:0] TURN_RIGHT    = 4'b1000;
    localparam logic [1:0] s1 = 2'b01;
    localparam logic [1:0] s2 = 2'b00;
    localparam logic [1:0] s3 = 2'b10;
    localparam logic [1:0] s4 = 2'b11;
    typedef enum logic [1:0] {OFF, STOPPED, DRIVING, DEAD} exec_state_t;
    function automatic logic [3:0] decode_cmd(input logic [3:0] ms);
        return (ms == MOVE_FORWARD || ms == MOVE_BACKWARD || ms == TURN_LEFT || ms == TURN_RIGHT) ? ms : STOP;
    endfunction
endpackage

// File: rtl/mileage_counter.sv
// mileage_counter: tick sub-counter with saturating mileage; in clk, rst, clr, en, tick; out mileage[15:0]
module mileage_counter #(
    parameter int MILE_TICKS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        tick,
    output logic [15:0] mileage
);
    localparam int SW = MILE_TICKS > 1 ? $clog2(MILE_TICKS) : 1;
    logic [SW-1:0] sub;
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sub     <= '0;
            mileage <= '0;
        end else if (en && tick) begin
            if (sub == SW'(MILE_TICKS - 1)) begin
                sub <= '0;
                if (mileage != 16'hFFFF) mileage <= mileage + 16'd1;
            end else begin
                sub <= sub + 1'b1;
            end
        end
    end
endmodule

// File: rtl/move_executor.sv
// move_executor: motor drive with reversal dead-time and mileage; in sys_clk, rst, power, tick, next_state, next_moving_state; out state, moving_state, drive_*, busy, mileage
module move_executor
    import car_pkg::*;
#(
    parameter int DEAD_TICKS = 10,
    parameter int MILE_TICKS = 1000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        power,
    input  logic        tick,
    input  logic [1:0]  next_state,
    input  logic [3:0]  next_moving_state,
    output logic [1:0]  state,
    output logic [3:0]  moving_state,
    output logic        drive_fwd,
    output logic        drive_back,
    output logic        drive_left,
    output logic        drive_right,
    output logic        busy,
    output logic [15:0] mileage
);
    exec_state_t fsm, fsm_n;
    logic [3:0] cmd, applied, applied_n, drv;
    logic [7:0] dcnt, dcnt_n;
    assign cmd = decode_cmd(moving_state);
    assign busy = fsm == DEAD;
    assign {drive_right, drive_left, drive_back, drive_fwd} = drv;
    always_comb begin
        fsm_n     = fsm;
        applied_n = applied;
        dcnt_n    = dcnt;
        if (!power) begin
            fsm_n = OFF;
        end else begin
            case (fsm)
                OFF: fsm_n = STOPPED;
                STOPPED: if (cmd != STOP) begin
                    fsm_n     = DRIVING;
                    applied_n = cmd;
                end
                DRIVING: if (cmd == STOP) begin
                    fsm_n = STOPPED;
                end else if (cmd != applied) begin
                    fsm_n  = DEAD;
                    dcnt_n = 8'(DEAD_TICKS);
                end
                DEAD: if (cmd == STOP) begin
                    fsm_n = STOPPED;
                end else if (dcnt == 8'd0) begin
                    fsm_n     = DRIVING;
                    applied_n = cmd;
                end else if (tick) begin
                    dcnt_n = dcnt - 8'd1;
                end
            endcase
        end
    end
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            fsm          <= OFF;
            applied      <= STOP;
            dcnt         <= '0;
            drv          <= '0;
            state        <= 2'b00;
            moving_state <= STOP;
        end else begin
            fsm          <= fsm_n;
            applied      <= applied_n;
            dcnt         <= dcnt_n;
            drv          <= fsm == DRIVING ? applied : 4'b0000;
            state        <= next_state;
            moving_state <= next_moving_state;
        end
    end
    mileage_counter #(.MILE_TICKS(MILE_TICKS)) u_mc (
        .clk     (sys_clk),
        .rst     (rst),
        .clr     (fsm == OFF),
        .en      (fsm == DRIVING && (applied == MOVE_FORWARD || applied == MOVE_BACKWARD)),
        .tick    (tick),
        .mileage (mileage)
    );
endmodule

// File: tb/tb_move_executor.sv
// tb_move_executor: directed self-checking bench for move_executor
module tb_move_executor;
    import car_pkg::*;
    logic        sys_clk = 0, rst = 1, power = 0, tick = 0, tick_en = 0;
    logic [1:0]  next_state = 2'b00;
    logic [3:0]  next_moving_state = STOP;
    logic [1:0]  state;
    logic [3:0]  moving_state, drv;
    logic        drive_fwd, drive_back, drive_left, drive_right, busy;
    logic [15:0] mileage;
    int total = 0, bad = 0, ticks_seen = 0, cyc = 0;
    assign drv = {drive_right, drive_left, drive_back, drive_fwd};
    move_executor #(.DEAD_TICKS(3), .MILE_TICKS(4)) dut (
        .sys_clk(sys_clk), .rst(rst), .power(power), .tick(tick),
        .next_state(next_state), .next_moving_state(next_moving_state),
        .state(state), .moving_state(moving_state),
        .drive_fwd(drive_fwd), .drive_back(drive_back), .drive_left(drive_left), .drive_right(drive_right),
        .busy(busy), .mileage(mileage)
    );
    always #5 sys_clk = ~sys_clk;
    always @(negedge sys_clk) begin
        cyc  = (cyc == 4) ? 0 : cyc + 1;
        tick = tick_en && (cyc == 4);
    end
    task automatic step();
        @(posedge sys_clk);
        #1;
        if (tick) ticks_seen++;
    endtask
    task automatic wait_ticks(input int n);
        int start;
        start = ticks_seen;
        for (int i = 0; i < 200 && ticks_seen - start < n; i++) step();
        total++;
        if (ticks_seen - start !== n) begin
            bad++;
            $display("FAIL wait_ticks: got %0d ticks want %0d", ticks_seen - start, n);
        end
    endtask
    task automatic wait_drive(input logic [3:0] exp);
        for (int i = 0; i < 100 && drv !== exp; i++) step();
        total++;
        if (drv !== exp) begin
            bad++;
            $display("FAIL wait_drive: got %b want %b", drv, exp);
        end
    endtask
    task automatic test_reset();
        rst = 1; power = 1; tick_en = 1;
        step(); step();
        total++;
        if ({drv, busy, mileage, state, moving_state} !== '0 || dut.fsm !== OFF) begin
            bad++;
            $display("FAIL reset_outputs: got drv=%b busy=%b mil=%h st=%b ms=%b fsm=%0d want all zero, OFF",
                     drv, busy, mileage, state, moving_state, dut.fsm);
        end
        rst = 0; tick_en = 0;
        step();
        total++;
        if (dut.fsm !== STOPPED) begin
            bad++;
            $display("FAIL reset_release: got fsm=%0d want %0d", dut.fsm, STOPPED);
        end
    endtask
    task automatic test_start();
        next_moving_state = MOVE_FORWARD; next_state = s3;
        step();
        total++;
        if (moving_state !== MOVE_FORWARD || state !== s3) begin
            bad++;
            $display("FAIL start_feedback: got ms=%b st=%b want 0001 10", moving_state, state);
        end
        step();
        total++;
        if (drv !== 4'b0000) begin
            bad++;
            $display("FAIL start_early: got %b want 0000", drv);
        end
        step();
        total++;
        if (drv !== MOVE_FORWARD || busy !== 1'b0) begin
            bad++;
            $display("FAIL start_drive: got drv=%b busy=%b want 0001 0", drv, busy);
        end
    endtask
    task automatic test_mileage();
        tick_en = 1;
        wait_ticks(4);
        total++;
        if (mileage !== 16'd1) begin
            bad++;
            $display("FAIL mileage_4: got %0d want 1", mileage);
        end
        wait_ticks(4);
        total++;
        if (mileage !== 16'd2) begin
            bad++;
            $display("FAIL mileage_8: got %0d want 2", mileage);
        end
        next_moving_state = TURN_LEFT;
        wait_drive(TURN_LEFT);
        wait_ticks(8);
        total++;
        if (mileage !== 16'd2 || drv !== TURN_LEFT) begin
            bad++;
            $display("FAIL mileage_left: got mil=%0d drv=%b want 2 0100", mileage, drv);
        end
    endtask
    task automatic do_reverse(input logic [3:0] target, input logic [3:0] final_cmd);
        int  start;
        bit  ok;
        next_moving_state = target;
        step(); step();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL dead_enter: got busy=%b want 1", busy);
        end
        next_moving_state = final_cmd;
        start = ticks_seen;
        ok = 1;
        for (int i = 0; i < 100 && ticks_seen - start < 3; i++) begin
            step();
            if (busy !== 1'b1 || drv !== 4'b0000) ok = 0;
        end
        total++;
        if (!ok || ticks_seen - start !== 3) begin
            bad++;
            $display("FAIL dead_hold: got ok=%0d ticks=%0d want 1 3", ok, ticks_seen - start);
        end
        step();
        total++;
        if (busy !== 1'b0 || drv !== 4'b0000) begin
            bad++;
            $display("FAIL dead_exit: got busy=%b drv=%b want 0 0000", busy, drv);
        end
        step();
        total++;
        if (drv !== final_cmd) begin
            bad++;
            $display("FAIL dead_drive: got %b want %b", drv, final_cmd);
        end
    endtask
    task automatic test_reversal();
        do_reverse(MOVE_FORWARD, MOVE_FORWARD);
        do_reverse(MOVE_BACKWARD, MOVE_BACKWARD);
        do_reverse(MOVE_FORWARD, MOVE_FORWARD);
        do_reverse(MOVE_BACKWARD, MOVE_FORWARD);
    endtask
    task automatic test_dead_stop();
        next_moving_state = MOVE_BACKWARD;
        step(); step();
        next_moving_state = STOP;
        step(); step();
        total++;
        if (busy !== 1'b0 || drv !== 4'b0000 || dut.fsm !== STOPPED) begin
            bad++;
            $display("FAIL dead_stop: got busy=%b drv=%b fsm=%0d want 0 0000 %0d", busy, drv, dut.fsm, STOPPED);
        end
    endtask
    task automatic test_saturate();
        next_moving_state = MOVE_FORWARD;
        wait_drive(MOVE_FORWARD);
        force dut.u_mc.mileage = 16'hFFFF;
        step();
        release dut.u_mc.mileage;
        wait_ticks(5);
        total++;
        if (mileage !== 16'hFFFF || drv !== MOVE_FORWARD) begin
            bad++;
            $display("FAIL mileage_sat: got mil=%h drv=%b want ffff 0001", mileage, drv);
        end
    endtask
    task automatic test_power();
        power = 0;
        step(); step();
        total++;
        if (drv !== 4'b0000 || mileage !== 16'd0 || dut.fsm !== OFF) begin
            bad++;
            $display("FAIL power_off: got drv=%b mil=%h fsm=%0d want 0000 0 OFF", drv, mileage, dut.fsm);
        end
        power = 1; next_moving_state = 4'b0110;
        repeat (6) step();
        total++;
        if (drv !== 4'b0000 || dut.fsm !== STOPPED) begin
            bad++;
            $display("FAIL bad_code_idle: got drv=%b fsm=%0d want 0000 STOPPED", drv, dut.fsm);
        end
        next_moving_state = MOVE_FORWARD;
        wait_drive(MOVE_FORWARD);
        next_moving_state = 4'b0110;
        step(); step(); step();
        total++;
        if (drv !== 4'b0000 || dut.fsm !== STOPPED) begin
            bad++;
            $display("FAIL bad_code_drive: got drv=%b fsm=%0d want 0000 STOPPED", drv, dut.fsm);
        end
    endtask
    task automatic test_reset_mid();
        next_moving_state = MOVE_FORWARD;
        wait_drive(MOVE_FORWARD);
        rst = 1;
        step(); step();
        total++;
        if ({drv, busy, mileage, state, moving_state} !== '0 || dut.fsm !== OFF) begin
            bad++;
            $display("FAIL reset_mid: got drv=%b busy=%b mil=%h st=%b ms=%b fsm=%0d want all zero, OFF",
                     drv, busy, mileage, state, moving_state, dut.fsm);
        end
        rst = 0;
        step();
        total++;
        if (dut.fsm !== STOPPED || drv !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid_release: got fsm=%0d drv=%b want STOPPED 0000", dut.fsm, drv);
        end
    endtask
    initial begin
        test_reset();
        test_start();
        test_mileage();
        test_reversal();
        test_dead_stop();
        test_saturate();
        test_power();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/move_executor.md
MOVE_EXECUTOR -- requirements
Module: move_executor

Interface
REQ-001 SHALL have parameter DEAD_TICKS, default 10, giving the all-off interval on direction reversal, in tick pulses (0..255).
REQ-002 SHALL have parameter MILE_TICKS, default 1000, giving the driving tick pulses per mileage unit (>=1).
REQ-003 SHALL have one clock and a synchronous active-high reset: sys_clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL have input power (1): car power enable.
REQ-005 SHALL have input tick (1): one-cycle strobe, 1 ms time base.
REQ-006 SHALL have input next_state (2): mode state requested by the driving-mode controller.
REQ-007 SHALL have input next_moving_state (4): movement command requested by the driving-mode controller.
REQ-008 SHALL have output state (2): registered next_state, fed back to the controller.
REQ-009 SHALL have output moving_state (4): registered next_moving_state, fed back to the controller.
REQ-010 SHALL have outputs drive_fwd, drive_back, drive_left and drive_right (1 each): motor control, at most one high.
REQ-011 SHALL have output busy (1): high while in DEAD.
REQ-012 SHALL have output mileage (16): completed distance units.

Function
REQ-013 SHALL register state<=next_state and moving_state<=next_moving_state every cycle; feedback latency 1 cycle.
REQ-014 SHALL decode cmd from moving_state: 0001 FWD, 0010 BACK, 0100 LEFT, 1000 RIGHT, 0000 STOP; every other code is treated as STOP.
REQ-015 SHALL implement FSM {OFF, STOPPED, DRIVING, DEAD}, with registers applied[3:0] and dcnt[7:0].
REQ-016 SHALL go from any state to OFF on the next cycle when power=0, taking priority over all other transitions; OFF→STOPPED when power=1.
REQ-017 STOPPED: SHALL go to DRIVING with applied<=cmd when cmd≠STOP.
REQ-018 DRIVING: SHALL stay while cmd==applied, go to STOPPED when cmd==STOP, and go to DEAD with dcnt<=DEAD_TICKS when cmd is a different non-STOP command.
REQ-019 DEAD: SHALL decrement dcnt on each tick while dcnt>0.
REQ-020 DEAD: SHALL, when dcnt==0, go to DRIVING with applied<=cmd if cmd≠STOP, otherwise go to STOPPED.
REQ-021 DEAD: SHALL go to STOPPED at once when cmd==STOP; a command change in DEAD SHALL NOT reload dcnt.
REQ-022 SHALL drive drive_* = decode(applied) only in DRIVING and all zero otherwise; drive_* SHALL be registered and change 1 cycle after the FSM transition.
REQ-023 SHALL give busy = (FSM==DEAD).
REQ-024 SHALL, in DRIVING with applied FWD or BACK, count tick pulses in a sub-counter.
REQ-025 SHALL, when a tick arrives with the sub-counter at MILE_TICKS-1, wrap the sub-counter to 0 and increment mileage.
REQ-026 SHALL saturate mileage at 16'hFFFF.
REQ-027 SHALL hold the sub-counter and mileage in every other state.
REQ-028 SHALL clear mileage and the sub-counter in OFF.
REQ-029 SHALL, when a tick coincides with a transition out of DRIVING, still count that tick.
REQ-030 SHALL make DEAD_TICKS=0 yield exactly one all-off cycle.

Reset
REQ-031 SHALL, while rst=1 at a sys_clk edge, set FSM=OFF, state=2'b00, moving_state=0000, applied=0000, dcnt=0, sub-counter=0, mileage=0, drive_*=0 and busy=0; rst SHALL override power and tick.
REQ-032 SHALL, on reset asserted mid-DEAD or mid-DRIVING, abandon any pending command; after release the block SHALL start in OFF.

Structure
REQ-033 SHALL place the moving-state encodings (STOP, MOVE_FORWARD, MOVE_BACKWARD, TURN_LEFT, TURN_RIGHT) and the mode-state encodings (s1=01, s2=00, s3=10, s4=11) in a shared package car_pkg, used by this block and the driving-mode controllers.
REQ-034 SHALL implement the tick sub-counter and saturating mileage in one sub-module, mileage_counter (inputs: clk, rst, clr, en, tick; output: mileage).

Verification
Every scenario SHALL use DEAD_TICKS=3, MILE_TICKS=4 and a tick every 5 cycles.
REQ-035 Reset: rst=1 for 2 cycles during DRIVING FWD → all outputs 0, FSM OFF; after release, power=1 → STOPPED next cycle.
REQ-036 Start: next_moving_state=0001 → moving_state=0001 after 1 cycle; drive_fwd=1 within 3 cycles.
REQ-037 Reversal: FWD→0010 → drive_* all 0 and busy=1 for 3 ticks, then drive_back=1; reverting to FWD during DEAD → drive_fwd=1 after the same 3 ticks.
REQ-038 Mileage: FWD for 8 ticks → mileage=2; LEFT for 8 ticks → mileage unchanged; preload to 0xFFFF and 4 more FWD ticks → mileage stays 0xFFFF.
REQ-039 Power: power=0 while DRIVING → drive_* = 0 and mileage=0 within 2 cycles; command 0110 → treated as STOP, no drive asserted.
